sound_ram_arbiter: RTL and testbench

- Shares the single-port sound program/work RAM (two 32K x 8 byte banks, 15-bit word address) between two requesters.
- Requester M is the main CPU 16-bit bus window (SDBEN-qualified); requester Z is the sound Z80 8-bit bus.
- Sequences each access as a request/grant/ack transaction and returns read data with a one-cycle ack.
- Sits between the main bus decode, the Z80 core wrapper and the byte-bank RAMs.

---
 rtl/sound_pkg.sv | 22 ++
 rtl/sound_ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sound_ram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types for the sound RAM arbiter: FSM states, requester identity and
// the byte-lane helper used on Z80 reads.
package sound_pkg;

   localparam int SOUND_RAM_AW = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DATA   = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_M = 1'b0,
      REQ_Z = 1'b1
   } requester_t;

   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sound_ram_arbiter.sv
// Shares the sound program/work RAM (two byte banks) between the main CPU window (M)
// and the sound Z80 (Z). Build option SOUND_ARB_ROUND_ROBIN_EN swaps the fixed-priority
// starvation guard for round-robin arbitration.
//
// state  | meaning
// IDLE   | sample requests, register the winner's address/we/data
// ACCESS | address (and write enables) presented to the banks
// DATA   | bank read data valid; capture into winner's dout, pulse its ack
module sound_ram_arbiter
   import sound_pkg::*;
#(
   parameter int AW         = SOUND_RAM_AW,
   parameter int Z_MAX_WAIT = 8
) (
   input  logic          CLK_32M,
   input  logic          RESET,
   input  logic          m_req,
   input  logic          m_we,
   input  logic [AW-1:0] m_addr,
   input  logic [1:0]    m_byte_sel,
   input  logic [15:0]   m_din,
   output logic [15:0]   m_dout,
   output logic          m_ack,
   input  logic          z_req,
   input  logic          z_we,
   input  logic [AW:0]   z_addr,
   input  logic [7:0]    z_din,
   output logic [7:0]    z_dout,
   output logic          z_ack,
   output logic [AW-1:0] ram_addr,
   output logic [15:0]   ram_din,
   output logic          ram_we_h,
   output logic          ram_we_l,
   input  logic [15:0]   ram_q
);

   arb_state_t state;
   requester_t owner;
   requester_t winner;
   logic       grant;
   logic       z_lane_hi;

`ifdef SOUND_ARB_ROUND_ROBIN_EN
   requester_t last_grant;

   always_comb begin
      grant  = 1'b0;
      winner = REQ_M;
      if (state == IDLE) begin
         if (m_req && z_req) begin
            grant  = 1'b1;
            winner = (last_grant == REQ_M) ? REQ_Z : REQ_M;
         end else if (m_req) begin
            grant  = 1'b1;
            winner = REQ_M;
         end else if (z_req) begin
            grant  = 1'b1;
            winner = REQ_Z;
         end
      end
   end

   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         last_grant <= REQ_Z;
      end else if (grant) begin
         last_grant <= winner;
      end
   end
`else
   localparam int            CW       = $clog2(Z_MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(Z_MAX_WAIT);

   logic [CW-1:0] z_wait_cnt;

   always_comb begin
      grant  = 1'b0;
      winner = REQ_M;
      if (state == IDLE) begin
         if (z_req && (z_wait_cnt >= WAIT_MAX)) begin
            grant  = 1'b1;
            winner = REQ_Z;
         end else if (m_req) begin
            grant  = 1'b1;
            winner = REQ_M;
         end else if (z_req) begin
            grant  = 1'b1;
            winner = REQ_Z;
         end
      end
   end

   // Z waiting while its own transaction is in flight does not count as starvation.
   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         z_wait_cnt <= '0;
      end else if (!z_req || (grant && winner == REQ_Z) ||
                   (state != IDLE && owner == REQ_Z)) begin
         z_wait_cnt <= '0;
      end else if (z_wait_cnt < WAIT_MAX) begin
         z_wait_cnt <= z_wait_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         owner     <= REQ_M;
         z_lane_hi <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         ram_we_h  <= 1'b0;
         ram_we_l  <= 1'b0;
         m_dout    <= '0;
         m_ack     <= 1'b0;
         z_dout    <= '0;
         z_ack     <= 1'b0;
      end else begin
         m_ack <= 1'b0;
         z_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner <= winner;
                  state <= ACCESS;
                  if (winner == REQ_M) begin
                     ram_addr <= m_addr;
                     ram_din  <= m_din;
                     ram_we_h <= m_we & m_byte_sel[1];
                     ram_we_l <= m_we & m_byte_sel[0];
                  end else begin
                     ram_addr  <= z_addr[AW:1];
                     ram_din   <= {z_din, z_din};
                     z_lane_hi <= z_addr[0];
                     ram_we_h  <= z_we & z_addr[0];
                     ram_we_l  <= z_we & ~z_addr[0];
                  end
               end
            end
            ACCESS: begin
               ram_we_h <= 1'b0;
               ram_we_l <= 1'b0;
               state    <= DATA;
            end
            DATA: begin
               if (owner == REQ_M) begin
                  m_dout <= ram_q;
                  m_ack  <= 1'b1;
               end else begin
                  z_dout <= lane_byte(ram_q, z_lane_hi);
                  z_ack  <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Directed bench for sound_ram_arbiter with a registered-read byte-bank RAM model.
// Arbitration expectations follow SOUND_ARB_ROUND_ROBIN_EN when defined.
module tb_sound_ram_arbiter;
   import sound_pkg::*;

   localparam int AW = SOUND_RAM_AW;

   logic          CLK_32M = 1'b0;
   logic          RESET;
   logic          m_req, m_we;
   logic [AW-1:0] m_addr;
   logic [1:0]    m_byte_sel;
   logic [15:0]   m_din, m_dout;
   logic          m_ack;
   logic          z_req, z_we;
   logic [AW:0]   z_addr;
   logic [7:0]    z_din, z_dout;
   logic          z_ack;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_din;
   logic          ram_we_h, ram_we_l;
   logic [15:0]   ram_q = '0;

   always #5 CLK_32M = ~CLK_32M;

   sound_ram_arbiter #(.AW(AW), .Z_MAX_WAIT(8)) dut (
      .CLK_32M   (CLK_32M),
      .RESET     (RESET),
      .m_req     (m_req),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_byte_sel(m_byte_sel),
      .m_din     (m_din),
      .m_dout    (m_dout),
      .m_ack     (m_ack),
      .z_req     (z_req),
      .z_we      (z_we),
      .z_addr    (z_addr),
      .z_din     (z_din),
      .z_dout    (z_dout),
      .z_ack     (z_ack),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we_h  (ram_we_h),
      .ram_we_l  (ram_we_l),
      .ram_q     (ram_q)
   );

   logic [15:0] mem [0:(1<<AW)-1];

   always @(posedge CLK_32M) begin
      if (ram_we_h) mem[ram_addr][15:8] <= ram_din[15:8];
      if (ram_we_l) mem[ram_addr][7:0]  <= ram_din[7:0];
      ram_q <= mem[ram_addr];
   end

   int we_h_cyc = 0, we_l_cyc = 0, m_ack_cnt = 0, z_ack_cnt = 0, overlap_cnt = 0;

   always @(negedge CLK_32M) begin
      if (ram_we_h) we_h_cyc++;
      if (ram_we_l) we_l_cyc++;
      if (m_ack) m_ack_cnt++;
      if (z_ack) z_ack_cnt++;
      if (m_ack && z_ack) overlap_cnt++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic m_access(input logic we, input logic [AW-1:0] addr, input logic [1:0] sel,
                           input logic [15:0] din, output int lat);
      @(posedge CLK_32M); #1;
      m_we = we; m_addr = addr; m_byte_sel = sel; m_din = din; m_req = 1'b1;
      we_h_cyc = 0; we_l_cyc = 0;
      lat = 0;
      do begin
         @(posedge CLK_32M); #1;
         lat++;
      end while (!m_ack && lat < 20);
      m_req = 1'b0;
      if (!m_ack) chk("m_timeout", 32'd0, 32'd1);
   endtask

   task automatic z_access(input logic we, input logic [AW:0] addr, input logic [7:0] din,
                           output int lat);
      @(posedge CLK_32M); #1;
      z_we = we; z_addr = addr; z_din = din; z_req = 1'b1;
      we_h_cyc = 0; we_l_cyc = 0;
      lat = 0;
      do begin
         @(posedge CLK_32M); #1;
         lat++;
      end while (!z_ack && lat < 20);
      z_req = 1'b0;
      if (!z_ack) chk("z_timeout", 32'd0, 32'd1);
   endtask

   task automatic m_write(input string tag, input logic [AW-1:0] addr, input logic [1:0] sel,
                          input logic [15:0] din);
      int lat;
      m_access(1'b1, addr, sel, din, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_we_h"}, 32'(we_h_cyc), 32'(sel[1]));
      chk({tag, "_we_l"}, 32'(we_l_cyc), 32'(sel[0]));
   endtask

   task automatic m_read(input string tag, input logic [AW-1:0] addr, input logic [15:0] exp);
      int lat;
      m_access(1'b0, addr, 2'b11, 16'h0000, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_dout"}, 32'(m_dout), 32'(exp));
      chk({tag, "_no_we"}, 32'(we_h_cyc + we_l_cyc), 32'd0);
   endtask

   task automatic z_write(input string tag, input logic [AW:0] addr, input logic [7:0] din,
                          input int exp_h, input int exp_l);
      int lat;
      z_access(1'b1, addr, din, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_we_h"}, 32'(we_h_cyc), 32'(exp_h));
      chk({tag, "_we_l"}, 32'(we_l_cyc), 32'(exp_l));
   endtask

   task automatic z_read(input string tag, input logic [AW:0] addr, input logic [7:0] exp);
      int lat;
      z_access(1'b0, addr, 8'h00, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_dout"}, 32'(z_dout), 32'(exp));
      chk({tag, "_no_we"}, 32'(we_h_cyc + we_l_cyc), 32'd0);
   endtask

   int seq [8];
   int ack_cyc [8];

   initial begin
      RESET = 1'b1;
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_byte_sel = 2'b00; m_din = '0;
      z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_din = '0;
      repeat (3) @(posedge CLK_32M);
      #1 RESET = 1'b0;
      @(posedge CLK_32M); #1;
      chk("rst_m_ack",    32'(m_ack), 32'd0);
      chk("rst_z_ack",    32'(z_ack), 32'd0);
      chk("rst_we",       32'({ram_we_h, ram_we_l}), 32'd0);
      chk("rst_m_dout",   32'(m_dout), 32'd0);
      chk("rst_z_dout",   32'(z_dout), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_din",  32'(ram_din), 32'd0);

      m_write("mw_full", 15'h0010, 2'b11, 16'h1234);
      m_read ("mr_full", 15'h0010, 16'h1234);
      m_write("mw_hi",   15'h0010, 2'b10, 16'hAB00);
      m_read ("mr_hi",   15'h0010, 16'hAB34);
      m_write("mw_none", 15'h0010, 2'b00, 16'hFFFF);
      m_read ("mr_none", 15'h0010, 16'hAB34);

      z_write("zw_hi", 16'h0021, 8'h5A, 1, 0);
      z_read ("zr_hi", 16'h0021, 8'h5A);
      m_read ("mr_zhi", 15'h0010, 16'h5A34);
      chk("z_dout_hold", 32'(z_dout), 32'h5A);
      z_read ("zr_lo", 16'h0020, 8'h34);
      z_write("zw_lo", 16'h0020, 8'hC3, 0, 1);
      m_read ("mr_zlo", 15'h0010, 16'h5AC3);
      chk("m_dout_hold", 32'(m_dout), 32'h5AC3);

      // Z request dropped right after being sampled still completes.
      @(posedge CLK_32M); #1;
      z_ack_cnt = 0;
      z_we = 1'b0; z_addr = 16'h0021; z_req = 1'b1;
      @(posedge CLK_32M); #1;
      z_req = 1'b0;
      repeat (5) @(posedge CLK_32M);
      #1;
      chk("zdrop_acks", 32'(z_ack_cnt), 32'd1);
      chk("zdrop_dout", 32'(z_dout), 32'h5A);

      // Both requesters held: check grant order and ack spacing.
      @(posedge CLK_32M); #1 RESET = 1'b1;
      @(posedge CLK_32M); #1 RESET = 1'b0;
      overlap_cnt = 0;
      m_we = 1'b0; m_addr = 15'h0010; z_we = 1'b0; z_addr = 16'h0021;
      m_req = 1'b1; z_req = 1'b1;
      begin
         int n = 0;
         int cyc = 0;
         while (n < 8 && cyc < 100) begin
            @(posedge CLK_32M); #1;
            cyc++;
            if (m_ack && n < 8) begin seq[n] = 0; ack_cyc[n] = cyc; n++; end
            if (z_ack && n < 8) begin seq[n] = 1; ack_cyc[n] = cyc; n++; end
         end
         if (n < 8) chk("arb_timeout", 32'(n), 32'd8);
         for (int i = 0; i < n; i++) begin
`ifdef SOUND_ARB_ROUND_ROBIN_EN
            chk($sformatf("arb_grant%0d", i), 32'(seq[i]), 32'(i % 2));
`else
            chk($sformatf("arb_grant%0d", i), 32'(seq[i]), (i % 4 == 3) ? 32'd1 : 32'd0);
`endif
            chk($sformatf("arb_ackcyc%0d", i), 32'(ack_cyc[i]), 32'(3 * (i + 1)));
         end
      end
      m_req = 1'b0; z_req = 1'b0;
      repeat (4) @(posedge CLK_32M);
      #1;
      chk("arb_overlap", 32'(overlap_cnt), 32'd0);
      chk("arb_m_dout",  32'(m_dout), 32'h5AC3);
      chk("arb_z_dout",  32'(z_dout), 32'h5A);

      // Reset during ACCESS of an M write: no write, no ack.
      @(posedge CLK_32M); #1;
      m_ack_cnt = 0;
      m_we = 1'b1; m_addr = 15'h0010; m_byte_sel = 2'b11; m_din = 16'h0F0F; m_req = 1'b1;
      @(posedge CLK_32M); #1;
      chk("rstmid_we_on", 32'({ram_we_h, ram_we_l}), 32'd3);
      #2 RESET = 1'b1;
      #1;
      chk("rstmid_we_off", 32'({ram_we_h, ram_we_l}), 32'd0);
      #1 m_req = 1'b0;
      RESET = 1'b0;
      repeat (6) @(posedge CLK_32M);
      #1;
      chk("rstmid_no_ack", 32'(m_ack_cnt), 32'd0);
      m_read("rstmid_keep", 15'h0010, 16'h5AC3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
